// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state type,
// default operand width and the iteration-counter width helper.
package shift_add_mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must hold WIDTH itself, since it steps once more on the last iteration.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_add_mult_seq_add_stage.sv
// WIDTH+1-bit conditional adder: adds the operand into the accumulator high half
// when enabled, keeping the carry-out as the top bit of the sum.
module add_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_op,
  input  logic [WIDTH-1:0] i_acc_hi,
  input  logic             i_en,
  output logic [WIDTH:0]   o_sum
);

  logic [WIDTH:0] w_addend;

  assign w_addend = i_en ? {1'b0, i_op} : '0;
  assign o_sum    = {1'b0, i_acc_hi} + w_addend;

endmodule

// File: rtl/shift_add_mult_seq.sv
// Sequential shift-add multiplier: one conditional add-and-shift per cycle, WIDTH+1
// cycles from accepted start to done. Optional signed mode: SHIFT_ADD_MULT_SIGNED_EN.
//
// Handshake: start is sampled only while busy=0; a, b (and sgn) are captured on
// that edge. done pulses for one cycle with product valid; product then holds.
module shift_add_mult_seq
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SHIFT_ADD_MULT_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output state_t             o_dbg_state
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg;
  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   w_result;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_neg_in;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  // Magnitudes are multiplied unsigned; -2^(WIDTH-1) maps onto itself as an unsigned value.
  assign w_a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
  assign w_b_mag  = (sgn && b[WIDTH-1]) ? -b : b;
  assign w_neg_in = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
  assign w_a_mag  = a;
  assign w_b_mag  = b;
  assign w_neg_in = 1'b0;
`endif

  add_stage #(.WIDTH(WIDTH)) u_add_stage (
    .i_op     (r_mcand),
    .i_acc_hi (r_acc[2*WIDTH-1:WIDTH]),
    .i_en     (r_mplier[0]),
    .o_sum    (w_sum)
  );

  // Shift {carry, sum, low half} right by one; the carry lands in the top bit.
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
  assign w_result   = r_neg ? -w_acc_next : w_acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      product  <= '0;
    end else if (w_accept) begin
      r_mcand  <= w_a_mag;
      r_mplier <= w_b_mag;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= w_neg_in;
    end else if (r_state == RUN) begin
      r_acc    <= w_acc_next;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        product <= w_result;
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign o_dbg_state = r_state;

endmodule

// File: doc/shift_add_mult_seq.md
SHIFT_ADD_MULT_SEQ -- requirements
Module: shift_add_mult_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to multiply a by b; sampled only in IDLE.
REQ-005 a  input  WIDTH  multiplicand.
REQ-006 b  input  WIDTH  multiplier.
REQ-007 busy  output  1  high while a multiplication is in progress.
REQ-008 done  output  1  one-cycle pulse when product is valid.
REQ-009 product  output  2*WIDTH  result; held stable until the next accepted start.

Function
REQ-010 FSM states SHALL be IDLE, RUN and DONE.
REQ-011 IDLE: start=1 at a rising edge SHALL latch a and b, clear the accumulator and iteration counter, and enter RUN.
REQ-012 RUN SHALL perform exactly WIDTH iterations, one per cycle: if the current multiplier LSB=1, add the multiplicand into the upper WIDTH+1 bits of the accumulator, then shift the accumulator {carry, acc} right by one.
REQ-013 The adder SHALL be WIDTH+1 bits wide; its carry-out SHALL never be lost.
REQ-014 After the WIDTH-th iteration, RUN SHALL go to DONE; product SHALL load the final accumulator value on that transition.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-016 Latency: start accepted at edge k; done=1 in cycle k+WIDTH+1, i.e. WIDTH+1 cycles after the edge.
REQ-017 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-018 start while busy=1 SHALL be ignored; a and b changes while busy SHALL NOT affect the result.
REQ-019 start held high continuously SHALL give back-to-back operations, with one IDLE cycle between the done pulse and the next acceptance.
REQ-020 Result SHALL be exact, a*b modulo 2^(2*WIDTH), which equals the full product for unsigned operands.
REQ-021 A zero operand SHALL still take the full WIDTH iterations; no early termination.

Reset
REQ-022 rst=1 SHALL force IDLE, busy=0, done=0, product=0, and clear the accumulator and counter, from any state.
REQ-023 Reset in RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.
REQ-024 rst SHALL take priority over start in the same cycle.

Configuration
REQ-025 Macro SHIFT_ADD_MULT_SIGNED_EN: when defined, add an input port sgn (1 bit), sampled with start.
REQ-026 With the macro and sgn=1, a and b SHALL be treated as two's complement.
  - The magnitudes SHALL be multiplied.
  - The product SHALL be negated on the RUN->DONE transition when the operand signs differ.
  - Latency SHALL be unchanged.
REQ-027 With the macro and sgn=0, or without the macro, behaviour SHALL be the unsigned behaviour of REQ-010..REQ-021; without the macro, sgn does not exist.
REQ-028 The most-negative operand (-2^(WIDTH-1)) SHALL give a correct result, e.g. WIDTH=8: -128*-128 = 16384.

Structure
REQ-029 Shared package shift_add_mult_pkg SHALL hold:
  - the state typedef (IDLE/RUN/DONE);
  - the default WIDTH constant;
  - the counter-width function clog2(WIDTH+1).
REQ-030 One sub-module, add_stage, SHALL implement the parametrised WIDTH+1-bit conditional adder (operand, accumulator-high, enable -> sum with carry); everything else stays in the top module.

Verification
REQ-031 WIDTH=4, a=15, b=15, start pulse -> busy for 5 cycles; done in cycle k+5; product=225 (8'hE1).
REQ-032 WIDTH=8, a=0, b=200 -> product=0 after the full 9-cycle latency; done pulse width exactly 1 cycle.
REQ-033 WIDTH=8, a=255, b=255, start held high for 3 operations -> each product=65025; accepts spaced WIDTH+2 cycles apart; a/b changed mid-RUN has no effect.
REQ-034 WIDTH=8, a=100, b=3, rst asserted at RUN iteration 4 -> no done pulse, product=0; next start with a=7, b=9 -> product=63.
REQ-035 SHIFT_ADD_MULT_SIGNED_EN defined, WIDTH=8, sgn=1:
  - a=-5, b=7 -> product=16'hFFDD (-35);
  - a=-128, b=-128 -> 16384;
  - sgn=0, a=8'hFB, b=7 -> 1757.
REQ-036 Random regression: 10,000 WIDTH=16 operand pairs checked against a reference multiply, plus a per-cycle check that busy and done match the state sequence.
